// File: rtl/cog_ctr_regif_if.sv
// Bus between the cog writeback/operand-fetch logic and the counter register stage.
interface cog_ctr_regif_if;
    logic        ena;
    logic        wr;
    logic [8:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd;
    logic [8:0]  rd_addr;
    logic [32:0] phsa;
    logic [32:0] phsb;
    logic        setctra;
    logic        setfrqa;
    logic        setphsa;
    logic        setctrb;
    logic        setfrqb;
    logic        setphsb;
    logic [31:0] data;
    logic        rd_hit;
    logic [31:0] rd_data;
    logic        rd_carry;

    modport master (
        output ena, wr, wr_addr, wr_data, rd, rd_addr, phsa, phsb,
        input  setctra, setfrqa, setphsa, setctrb, setfrqb, setphsb,
        input  data, rd_hit, rd_data, rd_carry
    );

    modport slave (
        input  ena, wr, wr_addr, wr_data, rd, rd_addr, phsa, phsb,
        output setctra, setfrqa, setphsa, setctrb, setfrqb, setphsb,
        output data, rd_hit, rd_data, rd_carry
    );
endinterface

// File: rtl/cog_ctr_regif.sv
// Counter special-register interface: stages writeback writes into per-counter
// set strobes, keeps CTR/FRQ shadows for operand readback, and offers a
// PHSA/PHSB pair snapshot so a PHSA-then-PHSB read sequence is coherent.
module cog_ctr_regif #(
    parameter int         SNAP_WIN  = 4,
    parameter logic [8:0] ADDR_BASE = 9'h1F8
) (
    input  logic              clk_cog,
    input  logic              res,
    cog_ctr_regif_if.slave    bus
);

    // Register offsets from ADDR_BASE; also the strobe bit positions.
    localparam logic [2:0] R_CTRA = 3'd0;
    localparam logic [2:0] R_CTRB = 3'd1;
    localparam logic [2:0] R_FRQA = 3'd2;
    localparam logic [2:0] R_FRQB = 3'd3;
    localparam logic [2:0] R_PHSA = 3'd4;
    localparam logic [2:0] R_PHSB = 3'd5;

    localparam logic [3:0] WIN_LOAD = 4'(SNAP_WIN);

    // Returns {hit, offset}; hit only for the six counter registers.
    function automatic logic [3:0] decode(input logic [8:0] a);
        logic [8:0] off;
        off = a - ADDR_BASE;
        if (off < 9'd6) return {1'b1, off[2:0]};
        return 4'b0000;
    endfunction

    logic        stg_v_q,   stg_v_d;
    logic [2:0]  stg_idx_q, stg_idx_d;
    logic [31:0] data_q,    data_d;
    logic [31:0] ctra_q,    ctra_d;
    logic [31:0] ctrb_q,    ctrb_d;
    logic [31:0] frqa_q,    frqa_d;
    logic [31:0] frqb_q,    frqb_d;
    logic [32:0] snap_q,    snap_d;
    logic [3:0]  win_q,     win_d;

    logic [3:0]  wr_dec;
    logic [3:0]  rd_dec;
    logic        wr_acc;
    logic        stg_live;
    logic [5:0]  strb;

    assign wr_dec   = decode(bus.wr_addr);
    assign rd_dec   = decode(bus.rd_addr);
    // A stopped cog accepts no writes; stage contents are dropped and never strobed.
    assign wr_acc   = bus.ena & bus.wr & wr_dec[3];
    assign stg_live = stg_v_q & bus.ena;

    // One-hot strobe for the staged register, driven purely from state.
    always_comb begin
        strb = 6'b000000;
        if (stg_live) strb = 6'(6'b000001 << stg_idx_q);
    end

    assign bus.setctra = strb[R_CTRA];
    assign bus.setctrb = strb[R_CTRB];
    assign bus.setfrqa = strb[R_FRQA];
    assign bus.setfrqb = strb[R_FRQB];
    assign bus.setphsa = strb[R_PHSA];
    assign bus.setphsb = strb[R_PHSB];
    assign bus.data    = data_q;

    // Next-state: staging, shadows (committed with the strobe), snapshot window.
    always_comb begin
        stg_v_d   = wr_acc;
        stg_idx_d = wr_acc ? wr_dec[2:0] : stg_idx_q;
        data_d    = wr_acc ? bus.wr_data : data_q;

        ctra_d = strb[R_CTRA] ? data_q : ctra_q;
        ctrb_d = strb[R_CTRB] ? data_q : ctrb_q;
        frqa_d = strb[R_FRQA] ? data_q : frqa_q;
        frqb_d = strb[R_FRQB] ? data_q : frqb_q;
        // Counters clear CTR when the cog stops; mirror that. FRQ is kept.
        if (!bus.ena) begin
            ctra_d = 32'h0;
            ctrb_d = 32'h0;
        end

        snap_d = snap_q;
        win_d  = win_q;
        if (!bus.ena) begin
            win_d = 4'd0;
        end else if (bus.rd && rd_dec == {1'b1, R_PHSA}) begin
            snap_d = bus.phsb;
            win_d  = WIN_LOAD;
        end else if (wr_acc && wr_dec[2:0] == R_PHSB) begin
            win_d = 4'd0;
        end else if (bus.rd && rd_dec == {1'b1, R_PHSB} && win_q != 4'd0) begin
            win_d = 4'd0;
        end else if (win_q != 4'd0) begin
            win_d = win_q - 4'd1;
        end
    end

    // State register; reset overrides everything.
    always_ff @(posedge clk_cog) begin
        if (res) begin
            stg_v_q   <= 1'b0;
            stg_idx_q <= 3'd0;
            data_q    <= 32'h0;
            ctra_q    <= 32'h0;
            ctrb_q    <= 32'h0;
            frqa_q    <= 32'h0;
            frqb_q    <= 32'h0;
            snap_q    <= 33'h0;
            win_q     <= 4'd0;
        end else begin
            stg_v_q   <= stg_v_d;
            stg_idx_q <= stg_idx_d;
            data_q    <= data_d;
            ctra_q    <= ctra_d;
            ctrb_q    <= ctrb_d;
            frqa_q    <= frqa_d;
            frqb_q    <= frqb_d;
            snap_q    <= snap_d;
            win_q     <= win_d;
        end
    end

    // Operand readback: staged write bypass, then snapshot, then shadow/live value.
    always_comb begin
        bus.rd_hit   = rd_dec[3];
        bus.rd_data  = 32'h0;
        bus.rd_carry = 1'b0;
        if (rd_dec[3]) begin
            if (stg_live && stg_idx_q == rd_dec[2:0]) begin
                bus.rd_data = data_q;
            end else begin
                case (rd_dec[2:0])
                    R_CTRA: bus.rd_data = ctra_q;
                    R_CTRB: bus.rd_data = ctrb_q;
                    R_FRQA: bus.rd_data = frqa_q;
                    R_FRQB: bus.rd_data = frqb_q;
                    R_PHSA: begin
                        bus.rd_data  = bus.phsa[31:0];
                        bus.rd_carry = bus.phsa[32];
                    end
                    R_PHSB: begin
                        if (win_q != 4'd0) begin
                            bus.rd_data  = snap_q[31:0];
                            bus.rd_carry = snap_q[32];
                        end else begin
                            bus.rd_data  = bus.phsb[31:0];
                            bus.rd_carry = bus.phsb[32];
                        end
                    end
                    default: bus.rd_data = 32'h0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cog_ctr_regif.sv
// Directed bench for cog_ctr_regif with a queue-based scoreboard.
module tb_cog_ctr_regif;

    localparam logic [8:0] A_CTRA = 9'h1F8;
    localparam logic [8:0] A_CTRB = 9'h1F9;
    localparam logic [8:0] A_FRQA = 9'h1FA;
    localparam logic [8:0] A_FRQB = 9'h1FB;
    localparam logic [8:0] A_PHSA = 9'h1FC;
    localparam logic [8:0] A_PHSB = 9'h1FD;

    localparam logic [5:0] M_CTRA = 6'b000001;
    localparam logic [5:0] M_CTRB = 6'b000010;
    localparam logic [5:0] M_FRQA = 6'b000100;
    localparam logic [5:0] M_FRQB = 6'b001000;
    localparam logic [5:0] M_PHSB = 6'b100000;
    localparam logic [5:0] M_NONE = 6'b000000;

    logic clk;
    logic res;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        int          at;
        logic [5:0]  mask;
        logic [31:0] data;
    } strb_t;

    typedef struct {
        string       name;
        logic        hit;
        logic [31:0] data;
        logic        carry;
    } rd_t;

    strb_t sq[$];
    rd_t   rq[$];

    cog_ctr_regif_if bus ();

    cog_ctr_regif #(.SNAP_WIN(4), .ADDR_BASE(9'h1F8)) dut (
        .clk_cog (clk),
        .res     (res),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare strobes and read responses against queued expectations.
    always @(negedge clk) begin
        logic [5:0] m;
        strb_t      e;
        rd_t        r;
        m = {bus.setphsb, bus.setphsa, bus.setfrqb, bus.setfrqa, bus.setctrb, bus.setctra};
        if (sq.size() > 0 && sq[0].at == cyc) begin
            e = sq.pop_front();
            checks++;
            if (m !== e.mask || bus.data !== e.data) begin
                errors++;
                $display("FAIL strobe cyc=%0d got mask=%b data=%h want mask=%b data=%h",
                         cyc, m, bus.data, e.mask, e.data);
            end
        end else if (m != 6'b0) begin
            checks++;
            errors++;
            $display("FAIL strobe_unexpected cyc=%0d got mask=%b data=%h want none", cyc, m, bus.data);
        end
        if (bus.rd) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected cyc=%0d no expectation queued", cyc);
            end else begin
                r = rq.pop_front();
                if (bus.rd_hit !== r.hit || bus.rd_data !== r.data || bus.rd_carry !== r.carry) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got hit=%b data=%h carry=%b want hit=%b data=%h carry=%b",
                             r.name, cyc, bus.rd_hit, bus.rd_data, bus.rd_carry, r.hit, r.data, r.carry);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    // One cycle with optional write and optional read; expectations queued here.
    task automatic op(input logic w, input logic [8:0] wa, input logic [31:0] wd, input logic [5:0] smask,
                      input logic r, input logic [8:0] ra, input string nm,
                      input logic eh, input logic [31:0] ed, input logic ec);
        strb_t s;
        rd_t   q;
        bus.wr      = w;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.rd      = r;
        bus.rd_addr = ra;
        if (smask != 6'b0) begin
            s.at   = cyc + 1;
            s.mask = smask;
            s.data = wd;
            sq.push_back(s);
        end
        if (r) begin
            q.name  = nm;
            q.hit   = eh;
            q.data  = ed;
            q.carry = ec;
            rq.push_back(q);
        end
        step();
    endtask

    task automatic wr_op(input logic [8:0] wa, input logic [31:0] wd, input logic [5:0] smask);
        op(1'b1, wa, wd, smask, 1'b0, 9'h0, "", 1'b0, 32'h0, 1'b0);
    endtask

    task automatic rd_op(input logic [8:0] ra, input string nm, input logic eh,
                         input logic [31:0] ed, input logic ec);
        op(1'b0, 9'h0, 32'h0, M_NONE, 1'b1, ra, nm, eh, ed, ec);
    endtask

    task automatic idle();
        step();
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        res         = 1'b1;
        bus.ena     = 1'b1;
        bus.wr      = 1'b0;
        bus.wr_addr = 9'h0;
        bus.wr_data = 32'h0;
        bus.rd      = 1'b0;
        bus.rd_addr = 9'h0;
        bus.phsa    = 33'h0_1234_5678;
        bus.phsb    = 33'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", bus.data, 32'h0);
        rd_op(A_CTRA, "rst_ctra", 1'b1, 32'h0, 1'b0);
        res = 1'b0;
        idle();

        // FRQA write: strobe one cycle later, bypass in strobe cycle, shadow after.
        wr_op(A_FRQA, 32'h0000_1000, M_FRQA);
        rd_op(A_FRQA, "frqa_bypass", 1'b1, 32'h0000_1000, 1'b0);
        rd_op(A_FRQA, "frqa_shadow", 1'b1, 32'h0000_1000, 1'b0);

        // Same-cycle write/read sees the old value; next cycle bypass; then shadow.
        op(1'b1, A_CTRA, 32'h1000_0000, M_CTRA, 1'b1, A_CTRA, "ctra_same_cycle", 1'b1, 32'h0, 1'b0);
        rd_op(A_CTRA, "ctra_bypass", 1'b1, 32'h1000_0000, 1'b0);
        rd_op(A_CTRA, "ctra_shadow", 1'b1, 32'h1000_0000, 1'b0);

        // Stage killed by ena low, write during ena low ignored, CTR shadows cleared.
        wr_op(A_FRQB, 32'h0000_0055, M_NONE);
        bus.ena = 1'b0;
        wr_op(A_CTRB, 32'h0000_DEAD, M_NONE);
        bus.ena = 1'b1;
        rd_op(A_CTRA, "ctra_after_stop", 1'b1, 32'h0, 1'b0);
        rd_op(A_FRQA, "frqa_kept", 1'b1, 32'h0000_1000, 1'b0);
        rd_op(A_CTRB, "ctrb_ignored", 1'b1, 32'h0, 1'b0);
        rd_op(A_FRQB, "frqb_dropped", 1'b1, 32'h0, 1'b0);

        // Pair snapshot: PHSB read within window returns captured value once.
        bus.phsb = 33'h1_0000_00AA;
        rd_op(A_PHSA, "phsa_live", 1'b1, 32'h1234_5678, 1'b0);
        bus.phsb = 33'h0_0000_00BB;
        idle();
        rd_op(A_PHSB, "phsb_snap", 1'b1, 32'h0000_00AA, 1'b1);
        rd_op(A_PHSB, "phsb_after_snap", 1'b1, 32'h0000_00BB, 1'b0);

        // Last cycle of window still returns the snapshot.
        bus.phsb = 33'h1_0000_00CC;
        rd_op(A_PHSA, "phsa_live2", 1'b1, 32'h1234_5678, 1'b0);
        bus.phsb = 33'h0_0000_00DD;
        repeat (3) idle();
        rd_op(A_PHSB, "phsb_win_last", 1'b1, 32'h0000_00CC, 1'b1);

        // Window expired: live value.
        rd_op(A_PHSA, "phsa_live3", 1'b1, 32'h1234_5678, 1'b0);
        bus.phsb = 33'h1_0000_00EE;
        repeat (4) idle();
        rd_op(A_PHSB, "phsb_win_expired", 1'b1, 32'h0000_00EE, 1'b1);

        // PHSA re-read inside window reloads the snapshot.
        bus.phsb = 33'h0_0000_0111;
        rd_op(A_PHSA, "phsa_live4", 1'b1, 32'h1234_5678, 1'b0);
        bus.phsb = 33'h1_0000_0222;
        rd_op(A_PHSA, "phsa_reload", 1'b1, 32'h1234_5678, 1'b0);
        bus.phsb = 33'h0_0000_0333;
        rd_op(A_PHSB, "phsb_reloaded", 1'b1, 32'h0000_0222, 1'b1);

        // Staged PHSB write outranks the snapshot and closes the window.
        rd_op(A_PHSA, "phsa_live5", 1'b1, 32'h1234_5678, 1'b0);
        bus.phsb = 33'h1_0000_0444;
        wr_op(A_PHSB, 32'h0000_CAFE, M_PHSB);
        rd_op(A_PHSB, "phsb_bypass", 1'b1, 32'h0000_CAFE, 1'b0);
        rd_op(A_PHSB, "phsb_live_after_wr", 1'b1, 32'h0000_0444, 1'b1);

        // Back-to-back writes: one strobe per cycle with matching data.
        wr_op(A_CTRB, 32'h0000_0011, M_CTRB);
        wr_op(A_FRQB, 32'h0000_0022, M_FRQB);
        wr_op(A_PHSB, 32'h0000_0033, M_PHSB);
        idle();
        chk("data_hold", bus.data, 32'h0000_0033);
        rd_op(A_CTRB, "ctrb_shadow", 1'b1, 32'h0000_0011, 1'b0);
        rd_op(A_FRQB, "frqb_shadow", 1'b1, 32'h0000_0022, 1'b0);

        // Reset together with a write: nothing staged, all shadows cleared.
        res = 1'b1;
        wr_op(A_CTRA, 32'h0000_0077, M_NONE);
        res = 1'b0;
        chk("rst_data2", bus.data, 32'h0);
        rd_op(A_CTRA, "rst2_ctra", 1'b1, 32'h0, 1'b0);
        rd_op(A_CTRB, "rst2_ctrb", 1'b1, 32'h0, 1'b0);
        rd_op(A_FRQA, "rst2_frqa", 1'b1, 32'h0, 1'b0);
        rd_op(A_FRQB, "rst2_frqb", 1'b1, 32'h0, 1'b0);

        // Non-counter addresses: no strobe, no hit, data unchanged.
        wr_op(9'h000, 32'h0000_0099, M_NONE);
        rd_op(9'h000, "miss_000", 1'b0, 32'h0, 1'b0);
        rd_op(9'h1FE, "miss_1fe", 1'b0, 32'h0, 1'b0);
        rd_op(9'h1F7, "miss_1f7", 1'b0, 32'h0, 1'b0);
        chk("data_after_miss", bus.data, 32'h0);

        repeat (3) idle();
        chk("strobe_queue_empty", 32'(sq.size()), 32'h0);
        chk("read_queue_empty", 32'(rq.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cog_ctr_regif.md
Name: cog_ctr_regif

Overview:
- Register-interface stage directly upstream of the two per-cog counter instances (A and B).
- Decodes cog writeback writes to the counter special registers and drives the counters' set strobes and data bus through one registered staging cycle.
- Provides source-operand readback of CTR/FRQ/PHS, with same-cycle write bypass and a coherent PHSA/PHSB pair-snapshot window.

Parameters:
- SNAP_WIN, 4, cycles after a PHSA read during which a PHSB read returns the snapshot (1..15).
- ADDR_BASE, 9'h1F8, address of CTRA; CTRB=+1, FRQA=+2, FRQB=+3, PHSA=+4, PHSB=+5.

Ports:
- clk_cog  in  1  cog clock; all state on rising edge.
- res  in  1  synchronous active-high reset.
- ena  in  1  cog enabled; low = cog stopped.
- wr  in  1  writeback strobe for wr_addr/wr_data.
- wr_addr  in  9  destination register address.
- wr_data  in  32  write data.
- rd  in  1  source-operand read request.
- rd_addr  in  9  source register address.
- phsa  in  33  live PHS from counter A (bit 32 = carry).
- phsb  in  33  live PHS from counter B.
- setctra, setfrqa, setphsa  out  1 each  set strobes to counter A.
- setctrb, setfrqb, setphsb  out  1 each  set strobes to counter B.
- data  out  32  shared write data to both counters.
- rd_hit  out  1  rd_addr is one of the six counter registers.
- rd_data  out  32  readback value (combinational from state and inputs).
- rd_carry  out  1  phs bit 32 for a PHS read, else 0.

Behaviour:
- Reset (res=1 at edge): all six strobes 0; data 0; staging-valid 0; ctra/ctrb/frqa/frqb shadows 0; snapshot 0; window counter 0. rd_data and rd_carry are 0 for non-hits. Reset takes priority over every other input.
- Write staging:
  - wr=1 with a decoded address at edge N loads stg_addr, stg_data and stg_v=1.
  - Exactly one strobe is high during cycle N+1, with data=stg_data. Latency is 1 cycle.
  - wr to a non-counter address leaves stg_v at 0 and produces no strobe.
  - Back-to-back writes on consecutive cycles each produce their own strobe on consecutive cycles. No stall is needed and none exists.
  - data holds its last value when no strobe is high.
- Shadows: ctrX/frqX shadows update at the edge that ends the strobe cycle, which is the same edge at which the counter latches the value.
- ena low:
  - Synchronously clears both ctr shadows, so they match the counters' ctr clear.
  - Drops stg_v and forces all strobes low.
  - Clears the snapshot window.
  - frq shadows are retained.
  - Writes presented while ena=0 are ignored.
- Readback (rd is qualifier only; rd_data is valid whenever rd_hit=1):
  - CTR and FRQ addresses return the shadow value.
  - PHSA and PHSB return live phsX[31:0]; rd_carry returns phsX[32].
  - Bypass: if stg_v=1 and stg_addr==rd_addr, return stg_data. For a PHS address, rd_carry is 0 in this case.
  - A non-counter address gives rd_hit=0, rd_data=0, rd_carry=0.
- Snapshot:
  - rd=1 for PHSA at edge N loads snap <= phsb (33 bits) and sets win <= SNAP_WIN.
  - win decrements once per cycle while nonzero.
  - While win!=0, a PHSB read returns snap instead of live phsb. That read clears win at the next edge.
  - Bypass outranks snapshot: a staged PHSB write wins.
  - A write to PHSB, or a new PHSA read, restarts or reloads the snapshot as stated above. Writes to PHSB clear win.
- Simultaneous events:
  - wr and rd in the same cycle to the same address: rd sees the previous staged or stored value, not the new wr_data.
  - A PHSA read while win!=0 reloads snap and win.
  - wr while the previous stage is still valid: the new write replaces the stage at the same edge the old strobe completes.
- No combinational path from wr/wr_data to any strobe or data output.

Test Plan:
- Reset then wr FRQA=32'h0000_1000 at cycle 5 -> setfrqa=1 and data=32'h1000 in cycle 6 only; a FRQA read in cycle 7 returns 32'h1000.
- wr CTRA=32'h1000_0000 at cycle 3, rd CTRA in cycle 4 -> rd_data=32'h1000_0000 via bypass; ena low in cycle 10 -> a CTRA read in cycle 11 returns 0, FRQA unchanged.
- phsb=33'h1_0000_00AA, rd PHSA at cycle 20, phsb changes to 33'h0_0000_00BB, rd PHSB at cycle 22 -> rd_data=32'hAA, rd_carry=1; a second PHSB read at cycle 23 returns 32'hBB, rd_carry=0.
- rd PHSA at cycle 30, PHSB read at cycle 30+SNAP_WIN+1 -> live phsb returned, not snapshot.
- wr CTRB, FRQB, PHSB on cycles 40/41/42 -> setctrb, setfrqb, setphsb high on 41/42/43 respectively, each one cycle, with matching data.
- res asserted on a cycle with wr pending in stage -> no strobe next cycle; all shadows read 0; wr to 9'h000 never strobes and reads rd_hit=0.
